// File: rtl/instr_feeder.sv
// instr_feeder: host-side sequencer for the CPU instruction interface.
// A small instruction buffer is loaded over the prog_* port while idle.
// On go, the first len entries are issued in order. Each entry gets a
// one-cycle load with the word on instr, then a one-cycle s pulse. The
// sequencer then waits for w to fall and rise again.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   prog_we/addr/data      buffer write port (ignored while busy)
//   prog_len               instruction count for the run, sampled on go
//   go                     run request, sampled only in IDLE
//   w                      CPU wait flag
//   instr, load, s         instruction word and strobes to the CPU
//   busy, done, err        run status (done/err are one-cycle pulses)
//   issued                 instructions completed in the current/last run
//
// Optional build macro: INSTR_FEEDER_WDOG_EN. It enables a per-instruction
// watchdog of WDOG_CYCLES cycles on the w handshake. When the watchdog
// fires, the run aborts with an err pulse.
module instr_feeder #(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int WDOG_CYCLES = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [15:0]   prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          go,
    input  logic          w,
    output logic [15:0]   instr,
    output logic          load,
    output logic          s,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   issued
);

    if (DEPTH != 2**AW || WDOG_CYCLES < 1) begin : g_bad_cfg
        $error("instr_feeder: DEPTH must equal 2**AW and WDOG_CYCLES must be >= 1");
    end

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, START, WLOW, WHIGH, DONE} state_t;

    state_t        state;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] ptr;
    logic [AW:0]   len;
    logic [AW-1:0] ptr_nxt;
    logic [AW:0]   issued_nxt;

    assign ptr_nxt    = ptr + 1'b1;     // wraps only when len == DEPTH
    assign issued_nxt = issued + 1'b1;

`ifdef INSTR_FEEDER_WDOG_EN
    localparam int WDW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYCLES - 1);
    logic [WDW-1:0] wdog_cnt;
`endif

    // The buffer has no reset, so its contents survive a reset.
    always_ff @(posedge clk) begin
        if (prog_we && !busy)
            mem[prog_addr] <= prog_data;
    end

    // The strobes and the instruction word are set on the edge that
    // enters their state. This way load is high exactly during LOAD and
    // s is high exactly during START.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            instr  <= '0;
            load   <= 1'b0;
            s      <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            issued <= '0;
            ptr    <= '0;
            len    <= '0;
`ifdef INSTR_FEEDER_WDOG_EN
            wdog_cnt <= '0;
`endif
        end else begin
            load <= 1'b0;
            s    <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        issued <= '0;
                        if (prog_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            len   <= (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
                            ptr   <= '0;
                            busy  <= 1'b1;
                            instr <= mem[{AW{1'b0}}];
                            load  <= 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    s     <= 1'b1;
                    state <= START;
                end
                START: begin
`ifdef INSTR_FEEDER_WDOG_EN
                    wdog_cnt <= '0;
`endif
                    state <= WLOW;
                end
                // A w still high from the previous instruction does not count.
                // The CPU must first drop w to show that it took the new word.
                WLOW: begin
                    if (!w)
                        state <= WHIGH;
                end
                WHIGH: begin
                    if (w) begin
                        issued <= issued_nxt;
                        ptr    <= ptr_nxt;
                        if (issued_nxt == len) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            instr <= mem[ptr_nxt];
                            load  <= 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef INSTR_FEEDER_WDOG_EN
            // When the watchdog fires, it overrides any WLOW/WHIGH transition
            // made above. The run then ends without done, and issued keeps
            // the count completed so far.
            if ((state == WLOW) || (state == WHIGH && !w)) begin
                if (wdog_cnt == WDOG_LAST) begin
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    wdog_cnt <= wdog_cnt + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_instr_feeder.sv
// Directed bench for instr_feeder, with a small CPU model on the w line.
module tb_instr_feeder;
    localparam int AW   = 4;
    localparam int DEPTH = 16;
    localparam int WDOG = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [15:0]   prog_data = '0;
    logic [AW:0]   prog_len = '0;
    logic          go = 1'b0;
    logic          w = 1'b1;
    logic [15:0]   instr;
    logic          load, s, busy, done, err;
    logic [AW:0]   issued;

    instr_feeder #(.DEPTH(DEPTH), .AW(AW), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .go(go), .w(w),
        .instr(instr), .load(load), .s(s), .busy(busy), .done(done),
        .err(err), .issued(issued)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // CPU model. At the negedge where s is seen, w is dropped drop_dly
    // cycles later and raised 4 cycles after that. The s pulse numbered
    // stuck_on is ignored, so w stays high for that instruction.
    int drop_dly = 1;
    int stuck_on = 0;
    int s_num = 0;
    int ph = 0;
    int tmr = 0;
    always @(negedge clk) begin
        if (s) begin
            s_num++;
            if (s_num != stuck_on) begin
                ph  = 1;
                tmr = drop_dly;
            end
        end else if (ph == 1) begin
            tmr--;
            if (tmr == 0) begin w = 1'b0; ph = 2; tmr = 4; end
        end else if (ph == 2) begin
            tmr--;
            if (tmr == 0) begin w = 1'b1; ph = 0; end
        end
    end

    // Monitor: logs every loaded word, counts done/err pulses, and checks
    // the load->s ordering.
    logic [15:0] log_q[$];
    int   done_cnt = 0;
    int   err_cnt  = 0;
    logic prev_load = 1'b0;
`ifdef INSTR_FEEDER_WDOG_EN
    int cyc = 0, s_cyc = 0, err_cyc = 0;
`endif
    always @(negedge clk) begin
`ifdef INSTR_FEEDER_WDOG_EN
        cyc++;
        if (s)   s_cyc = cyc;
        if (err) err_cyc = cyc;
`endif
        if (load) begin
            log_q.push_back(instr);
            chk("load_s_excl", {31'd0, s}, 32'd0);
        end
        if (s) chk("s_after_load", {31'd0, prev_load}, 32'd1);
        if (done) done_cnt++;
        if (err) err_cnt++;
        prev_load = load;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic prog_wr(input logic [AW-1:0] a, input logic [15:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic start_run(input int n);
        log_q.delete();
        s_num = 0;
        prog_len = n[AW:0];
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("go_busy", {31'd0, busy}, 32'd1);
        chk("go_load", {31'd0, load}, 32'd1);
    endtask

    task automatic wait_end();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int k = 0;
        while (done_cnt == d0 && err_cnt == e0 && k < 300) begin
            tick();
            k++;
        end
        chk("run_timeout", {31'd0, k < 300}, 32'd1);
    endtask

    logic [15:0] exp3 [3] = '{16'hD007, 16'hD102, 16'hD30A};
    int exp_err = 0;

    initial begin
        repeat (2) tick();
        chk("rst_instr", {16'd0, instr}, 32'd0);
        chk("rst_load", {31'd0, load}, 32'd0);
        chk("rst_s", {31'd0, s}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_issued", {27'd0, issued}, 32'd0);
        reset = 1'b0;
        tick();

        // Zero-length run: done pulses once, busy stays low.
        prog_len = '0; go = 1'b1;
        tick();
        go = 1'b0;
        chk("len0_done", {31'd0, done}, 32'd1);
        chk("len0_busy", {31'd0, busy}, 32'd0);
        chk("len0_issued", {27'd0, issued}, 32'd0);
        tick();
        chk("len0_done_clr", {31'd0, done}, 32'd0);
        chk("len0_busy2", {31'd0, busy}, 32'd0);

        prog_wr(4'd0, 16'hD007);
        prog_wr(4'd1, 16'hD102);
        prog_wr(4'd2, 16'hD30A);
        prog_wr(4'd3, 16'h1234);

        // Basic three-instruction run.
        start_run(3);
        chk("run1_first_instr", {16'd0, instr}, 32'hD007);
        wait_end();
        chk("run1_done_cnt", done_cnt, 32'd2);
        chk("run1_nload", log_q.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < log_q.size()) chk($sformatf("run1_instr%0d", i), {16'd0, log_q[i]}, {16'd0, exp3[i]});
        tick();
        chk("run1_busy_off", {31'd0, busy}, 32'd0);
        chk("run1_issued", {27'd0, issued}, 32'd3);
        chk("run1_instr_kept", {16'd0, instr}, 32'hD30A);

        // Buffer write while busy must be ignored.
        start_run(3);
        tick();
        chk("wbusy_busy", {31'd0, busy}, 32'd1);
        prog_wr(4'd1, 16'hFFFF);
        wait_end();
        chk("wbusy_slot1", (log_q.size() > 1) ? {16'd0, log_q[1]} : 32'd0, 32'hD102);
        tick();
        start_run(3);
        wait_end();
        chk("rerun_slot1", (log_q.size() > 1) ? {16'd0, log_q[1]} : 32'd0, 32'hD102);
        tick();
        chk("rerun_issued", {27'd0, issued}, 32'd3);

        // Stale w: w stays high through START and drops only 3 cycles later.
        drop_dly = 3;
        start_run(2);
        repeat (4) tick();
        chk("stale_hold", {27'd0, issued}, 32'd0);
        wait_end();
        tick();
        chk("stale_issued", {27'd0, issued}, 32'd2);
        chk("stale_nload", log_q.size(), 32'd2);
        drop_dly = 1;

        // Reset during WHIGH of the second instruction.
        begin
            int k = 0;
            start_run(3);
            while (log_q.size() < 2 && k < 100) begin tick(); k++; end
            while (w !== 1'b0 && k < 100) begin tick(); k++; end
            chk("rst_mid_reach", {31'd0, k < 100}, 32'd1);
        end
        tick();
        reset = 1'b1;
        tick();
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_load", {31'd0, load}, 32'd0);
        chk("rstmid_s", {31'd0, s}, 32'd0);
        chk("rstmid_issued", {27'd0, issued}, 32'd0);
        chk("rstmid_instr", {16'd0, instr}, 32'd0);
        reset = 1'b0;
        repeat (8) tick();
        start_run(3);
        chk("restart_instr0", {16'd0, instr}, 32'hD007);
        wait_end();
        tick();
        chk("restart_issued", {27'd0, issued}, 32'd3);
        chk("restart_nload", log_q.size(), 32'd3);

`ifdef INSTR_FEEDER_WDOG_EN
        // w never drops after the second s, so the watchdog fires.
        begin
            int d0 = done_cnt;
            exp_err = 1;
            stuck_on = 2;
            start_run(3);
            wait_end();
            chk("wdog_err", err_cnt, 32'd1);
            chk("wdog_no_done", done_cnt, d0);
            chk("wdog_busy", {31'd0, busy}, 32'd0);
            chk("wdog_issued", {27'd0, issued}, 32'd1);
            chk("wdog_gap", err_cyc - s_cyc, WDOG + 1);
            stuck_on = 0;
            tick();
        end
`endif
        chk("err_total", err_cnt, exp_err);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
